ppgen_pipe: RTL and testbench

//  Front end of the 12b approximate signed multiplier. Accepts operand pairs over a

---
 rtl/mult_pkg.sv | 23 ++
 rtl/ppgen_row.sv | 14 +
 rtl/ppgen_pipe.sv | 97 +++++++++
 tb/tb_ppgen_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants, types and PP rule for the 12b approximate multiplier
package mult_pkg;

    localparam int W      = 12;
    localparam int PP_W   = W * W;
    localparam int PROD_W = 2 * W;

    // Row i of the array holds the partial product for multiplier bit b[i]
    typedef logic [W-1:0][W-1:0] pp_arr_t;

    // Modified Baugh-Wooley partial products; correction constants are left to ppcom
    function automatic logic [PP_W-1:0] bw_pp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PP_W-1:0] pp;
        pp = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp[W*i+j] = (a[j] & b[i]) ^ ((i == W-1) ^ (j == W-1));
            end
        end
        return pp;
    endfunction

endpackage

// File: rtl/ppgen_row.sv
// rtl/ppgen_row.sv - one Baugh-Wooley partial-product row
module ppgen_row
    import mult_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic         bi,
    input  logic         is_last_row,
    output logic [W-1:0] row
);

    // Sign column is inverted on ordinary rows; all other columns are inverted on the last row
    assign row = (a & {W{bi}}) ^ {~is_last_row, {(W-1){is_last_row}}};

endmodule

// File: rtl/ppgen_pipe.sv
// rtl/ppgen_pipe.sv - two-stage handshaked partial-product generator
module ppgen_pipe
    import mult_pkg::*;
#(
    parameter int TAG_W = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PP_W-1:0]   pp_out,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero
);

    logic              s1_valid_q, s1_valid_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d;
    logic              zero1_q, zero1_d;
    logic              s2_valid_q, s2_valid_d;
    logic [PP_W-1:0]   pp_q, pp_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;
    logic              zero2_q, zero2_d;

    logic              s1_ready;
    logic              s2_ready;
    logic              in_fire;
    logic              s1_fire;
    pp_arr_t           pp_rows;

    // One row generator per multiplier bit, fed from the S1 operand registers
    for (genvar gi = 0; gi < W; gi++) begin : g_row
        ppgen_row u_row (
            .a           (a_q),
            .bi          (b_q[gi]),
            .is_last_row (1'(gi == W-1)),
            .row         (pp_rows[gi])
        );
    end

    // Ready chain and stage advance; a stage accepts when empty or when it is draining this cycle
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        s1_ready   = !s1_valid_q || s2_ready;
        in_fire    = in_valid && s1_ready;
        s1_fire    = s1_valid_q && s2_ready;

        s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
        a_d        = in_fire ? in_a : a_q;
        b_d        = in_fire ? in_b : b_q;
        tag1_d     = in_fire ? in_tag : tag1_q;
        zero1_d    = in_fire ? ((in_a == '0) || (in_b == '0)) : zero1_q;

        s2_valid_d = s1_fire || (s2_valid_q && !out_ready);
        pp_d       = s1_fire ? PP_W'(pp_rows) : pp_q;
        tag2_d     = s1_fire ? tag1_q : tag2_q;
        zero2_d    = s1_fire ? zero1_q : zero2_q;
    end

    // Stage registers; reset drops every in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            tag1_q     <= '0;
            zero1_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            pp_q       <= '0;
            tag2_q     <= '0;
            zero2_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            tag1_q     <= tag1_d;
            zero1_q    <= zero1_d;
            s2_valid_q <= s2_valid_d;
            pp_q       <= pp_d;
            tag2_q     <= tag2_d;
            zero2_q    <= zero2_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign pp_out    = pp_q;
    assign out_tag   = tag2_q;
    assign out_zero  = zero2_q;

endmodule

// File: tb/tb_ppgen_pipe.sv
// tb/tb_ppgen_pipe.sv - directed and streaming bench for ppgen_pipe
module tb_ppgen_pipe;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:0]   in_a = '0;
    logic [11:0]   in_b = '0;
    logic [3:0]    in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [143:0]  pp_out;
    logic [3:0]    out_tag;
    logic          out_zero;

    int errors = 0;
    int checks = 0;

    ppgen_pipe #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp_out    (pp_out),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] exp_pp(input logic [11:0] a, input logic [11:0] b);
        logic [143:0] r;
        logic [11:0]  row;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            row = b[i] ? a : 12'h000;
            row = row ^ ((i == 11) ? 12'h7FF : 12'h800);
            r[12*i +: 12] = row;
        end
        return r;
    endfunction

    function automatic logic [23:0] sum_pp(input logic [143:0] pp);
        logic [23:0] s;
        s = 24'h801000;
        for (int i = 0; i < 12; i++) s = s + (24'(pp[12*i +: 12]) << i);
        return s;
    endfunction

    function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b);
        logic signed [23:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [3:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (pp_out !== '0) begin errors++; $display("FAIL reset_pp got=%h want=0", pp_out); end
        checks++; if (out_tag !== 4'h0 || out_zero !== 1'b0) begin errors++; $display("FAIL reset_tag_zero got=%h/%b want=0/0", out_tag, out_zero); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_one_times_one;
        logic [11:0] want;
        out_ready = 1'b1;
        send(12'h001, 12'h001, 4'h3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b want=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_two got=%b want=1", out_valid); end
        for (int i = 0; i < 12; i++) begin
            want = (i == 0) ? 12'h801 : ((i == 11) ? 12'h7FF : 12'h800);
            checks++;
            if (pp_out[12*i +: 12] !== want) begin errors++; $display("FAIL one_row%0d got=%h want=%h", i, pp_out[12*i +: 12], want); end
        end
        checks++; if (out_zero !== 1'b0 || out_tag !== 4'h3) begin errors++; $display("FAIL one_side got=%b/%h want=0/3", out_zero, out_tag); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL one_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_minus_one_sq;
        logic [11:0] want;
        out_ready = 1'b1;
        send(12'hFFF, 12'hFFF, 4'h5);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m1_valid got=%b want=1", out_valid); end
        for (int i = 0; i < 12; i++) begin
            want = (i == 11) ? 12'h800 : 12'h7FF;
            checks++;
            if (pp_out[12*i +: 12] !== want) begin errors++; $display("FAIL m1_row%0d got=%h want=%h", i, pp_out[12*i +: 12], want); end
        end
        checks++; if (sum_pp(pp_out) !== 24'h000001) begin errors++; $display("FAIL m1_prod got=%h want=000001", sum_pp(pp_out)); end
        @(negedge clk);
    endtask

    task automatic test_zero_operand;
        logic [11:0] want;
        out_ready = 1'b1;
        send(12'h000, 12'h5A5, 4'hA);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got=%b want=1", out_valid); end
        for (int i = 0; i < 12; i++) begin
            want = (i == 11) ? 12'h7FF : 12'h800;
            checks++;
            if (pp_out[12*i +: 12] !== want) begin errors++; $display("FAIL zero_row%0d got=%h want=%h", i, pp_out[12*i +: 12], want); end
        end
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag got=%b want=1", out_zero); end
        checks++; if (out_tag !== 4'hA) begin errors++; $display("FAIL zero_tag got=%h want=A", out_tag); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [11:0]  va [8];
        logic [11:0]  vb [8];
        logic [143:0] hold_pp;
        logic [3:0]   hold_tag;
        logic         hold_v;
        logic         fire;
        int           p;
        int           q;
        p = 0;
        q = 0;
        hold_v = 1'b0;
        hold_pp = '0;
        hold_tag = '0;
        for (int k = 0; k < 8; k++) begin
            va[k] = 12'($urandom);
            vb[k] = 12'($urandom);
        end
        for (int cyc = 0; cyc < 80 && q < 8; cyc++) begin
            out_ready = (cyc < 4) ? 1'b0 : (cyc % 2 == 0);
            in_valid  = (p < 8);
            if (p < 8) begin
                in_a = va[p];
                in_b = vb[p];
                in_tag = 4'(p);
            end
            #1;
            if (cyc < 4) begin
                checks++;
                if (in_ready !== (cyc < 2)) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, (cyc < 2)); end
            end
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || pp_out !== hold_pp || out_tag !== hold_tag) begin
                    errors++; $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_tag, hold_tag);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_tag !== 4'(q)) begin errors++; $display("FAIL bp_order got=%h want=%h", out_tag, 4'(q)); end
                checks++;
                if (pp_out !== exp_pp(va[q], vb[q])) begin errors++; $display("FAIL bp_pp idx=%0d got=%h want=%h", q, pp_out, exp_pp(va[q], vb[q])); end
                q++;
            end
            hold_v   = out_valid && !out_ready;
            hold_pp  = pp_out;
            hold_tag = out_tag;
            fire     = in_valid && in_ready;
            @(posedge clk);
            if (fire) p++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (q != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", q); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        int wait_cnt;
        out_ready = 1'b0;
        send(12'h111, 12'h222, 4'h1);
        send(12'h333, 12'h444, 4'h2);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre got=%b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_async got=%b want=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_release got=%b/%b want=1/0", in_ready, out_valid); end
        @(negedge clk);
        out_ready = 1'b1;
        send(12'h123, 12'h456, 4'h7);
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 6) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_timeout got=%b want=1", out_valid); end
        checks++;
        if (out_tag !== 4'h7 || pp_out !== exp_pp(12'h123, 12'h456)) begin errors++; $display("FAIL rm_first got=%h want=7", out_tag); end
        @(negedge clk);
    endtask

    task automatic test_random_stream;
        logic [11:0]  qa [$];
        logic [11:0]  qb [$];
        logic [3:0]   qt [$];
        logic [11:0]  ea;
        logic [11:0]  eb;
        logic [3:0]   et;
        logic [143:0] hold_pp;
        logic         hold_v;
        logic         fire;
        int           p;
        int           q;
        int           n;
        n = 11000;
        p = 0;
        q = 0;
        hold_v = 1'b0;
        hold_pp = '0;
        for (int cyc = 0; cyc < 40000 && q < n; cyc++) begin
            out_ready = (cyc < 10002) ? 1'b1 : 1'($urandom);
            in_valid  = (p < n);
            in_a      = 12'($urandom);
            in_b      = 12'($urandom);
            if ($urandom_range(0, 63) == 0) in_a = 12'h000;
            in_tag    = 4'(p);
            #1;
            if (cyc < 10002 && p < n) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL rs_rate cyc=%0d got=%b want=1", cyc, in_ready); end
            end
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || pp_out !== hold_pp) begin errors++; $display("FAIL rs_stable cyc=%0d got=%b want=1", cyc, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++; $display("FAIL rs_spurious got=%h want=none", out_tag);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    et = qt.pop_front();
                    if (pp_out !== exp_pp(ea, eb) || out_tag !== et || out_zero !== (ea == 0 || eb == 0)) begin
                        errors++; $display("FAIL rs_pp idx=%0d a=%h b=%h got=%h want=%h", q, ea, eb, pp_out, exp_pp(ea, eb));
                    end
                    checks++;
                    if (sum_pp(pp_out) !== ref_prod(ea, eb)) begin
                        errors++; $display("FAIL rs_prod a=%h b=%h got=%h want=%h", ea, eb, sum_pp(pp_out), ref_prod(ea, eb));
                    end
                end
                q++;
            end
            hold_v  = out_valid && !out_ready;
            hold_pp = pp_out;
            fire    = in_valid && in_ready;
            @(posedge clk);
            if (fire) begin
                qa.push_back(in_a);
                qb.push_back(in_b);
                qt.push_back(in_tag);
                p++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (q != n) begin errors++; $display("FAIL rs_count got=%0d want=%0d", q, n); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_one_times_one;
        test_minus_one_sq;
        test_zero_operand;
        test_backpressure;
        test_reset_mid;
        test_random_stream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
